// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter serialising RF (1 byte) and ALU (2 byte) responses onto the TX FIFO write port.
// Define TX_RESP_HEADER_EN to prefix every response with a source tag byte.
module tx_resp_arbiter #(
  parameter int unsigned             DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]   RF_TAG     = DATA_WIDTH'(8'h52),
  parameter logic [DATA_WIDTH-1:0]   ALU_TAG    = DATA_WIDTH'(8'h41)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rf_valid,
  input  logic [DATA_WIDTH-1:0]     i_rf_data,
  output logic                      o_rf_ready,
  input  logic                      i_alu_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_alu_data,
  output logic                      o_alu_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wr,
  output logic [DATA_WIDTH-1:0]     o_tx_data_out,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
`ifdef TX_RESP_HEADER_EN
    StHdr   = 2'd1,
`endif
    StByte0 = 2'd2,
    StByte1 = 2'd3
  } state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic [2*DATA_WIDTH-1:0]   r_hold;
  logic                      r_src_alu;
  logic                      r_last_alu;
  logic                      w_idle;
  logic                      w_grant_rf;
  logic                      w_grant_alu;
  logic                      w_handshake;

  // Tie goes to whichever source was not served last; reset leaves ALU as last so RF wins first.
  always_comb begin
    w_idle      = (r_state == StIdle);
    w_grant_rf  = i_rf_valid & (~i_alu_valid | r_last_alu);
    w_grant_alu = i_alu_valid & (~i_rf_valid | ~r_last_alu);
    o_rf_ready  = w_idle & w_grant_rf & ~i_rst;
    o_alu_ready = w_idle & w_grant_alu & ~i_rst;
    w_handshake = o_rf_ready | o_alu_ready;
    o_fifo_wr   = ~w_idle & ~i_fifo_full;
    o_busy      = ~w_idle;
  end

  always_comb begin
    o_tx_data_out = '0;
    unique case (r_state)
`ifdef TX_RESP_HEADER_EN
      StHdr:   o_tx_data_out = r_src_alu ? ALU_TAG : RF_TAG;
`endif
      StByte0: o_tx_data_out = r_hold[DATA_WIDTH-1:0];
      StByte1: o_tx_data_out = r_hold[2*DATA_WIDTH-1:DATA_WIDTH];
      default: o_tx_data_out = '0;
    endcase
  end

`ifndef TX_RESP_HEADER_EN
  logic w_unused_tags;
  assign w_unused_tags = ^{RF_TAG, ALU_TAG};
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_handshake) begin
`ifdef TX_RESP_HEADER_EN
          w_state_next = StHdr;
`else
          w_state_next = StByte0;
`endif
        end
      end
`ifdef TX_RESP_HEADER_EN
      StHdr:   if (o_fifo_wr) w_state_next = StByte0;
`endif
      StByte0: if (o_fifo_wr) w_state_next = r_src_alu ? StByte1 : StIdle;
      StByte1: if (o_fifo_wr) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_hold     <= '0;
      r_src_alu  <= 1'b0;
      r_last_alu <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_handshake) begin
        r_hold     <= o_rf_ready ? {{DATA_WIDTH{1'b0}}, i_rf_data} : i_alu_data;
        r_src_alu  <= o_alu_ready;
        r_last_alu <= o_alu_ready;
      end
    end
  end

endmodule
